// File: rtl/rv_muldiv_if.sv
// rv_muldiv_if: request/response bundle between the execute stage and the
// iterative RV32M multiply/divide unit.
//   start  : request a new operation (sampled only while the unit is idle)
//   funct3 : M-extension op select (MUL..REMU)
//   A, B   : selected rs1/rs2 operands
//   result : registered result, valid while done is high
//   done   : one-cycle completion pulse
//   busy   : unit is computing or presenting a result
//   stall  : freeze PC / suppress writeback while high
interface rv_muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        stall;

  modport master (output start, funct3, A, B,
                  input  result, done, busy, stall);
  modport slave  (input  start, funct3, A, B,
                  output result, done, busy, stall);
endinterface

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rv_muldiv_if slave (start/funct3/A/B in, result/done/busy/stall out)
// Multiply is shift-add on magnitudes into a 64-bit accumulator; divide is
// restoring division on magnitudes. Signs are reapplied on the final cycle.
// Divide-by-zero and signed overflow resolve on the accept edge.
module rv_muldiv_unit (
  input logic       clk,
  input logic       rst,
  rv_muldiv_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [31:0] mcand_q, mcand_d;   // multiplicand (mul) or divisor (div)
  logic [63:0] acc_q, acc_d;       // {hi, lo}: product / {remainder, quotient}
  logic [31:0] result_q, result_d;

  // ---------------- accept-side decode ----------------
  logic [2:0]  f3;
  logic        accept, sgn_a, sgn_b, neg_a, neg_b, neg_res;
  logic        div0, ovf, special;
  logic [31:0] mag_a, mag_b, spec_res;

  assign f3     = bus.funct3;
  assign accept = (state_q == S_IDLE) && bus.start;

  // MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed
  assign sgn_a = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
  assign sgn_b = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
  assign neg_a = sgn_a && bus.A[31];
  assign neg_b = sgn_b && bus.B[31];
  assign mag_a = neg_a ? (~bus.A + 32'd1) : bus.A;
  assign mag_b = neg_b ? (~bus.B + 32'd1) : bus.B;
  // REM follows the dividend's sign; every other op follows sign(A)^sign(B)
  assign neg_res = (f3 == 3'b110) ? neg_a : (neg_a ^ neg_b);

  assign div0     = f3[2] && (bus.B == 32'd0);
  assign ovf      = f3[2] && !f3[0] && (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
  assign special  = div0 || ovf;
  assign spec_res = div0 ? (f3[1] ? bus.A : 32'hFFFF_FFFF)
                         : (f3[1] ? 32'd0 : 32'h8000_0000);

  // ---------------- one iteration ----------------
  logic [32:0] mul_sum, div_sh, div_diff;
  logic        div_ge;
  logic [63:0] mul_next, div_next, acc_step, prod_s;
  logic [31:0] quot, rem, div_res, mul_res, final_res;

  // add multiplicand into the upper half when multiplier LSB is set, then shift
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // shift next dividend bit into the partial remainder and trial-subtract
  assign div_sh   = {acc_q[63:32], acc_q[31]};
  assign div_diff = div_sh - {1'b0, mcand_q};
  assign div_ge   = !div_diff[32];
  assign div_next = {(div_ge ? div_diff[31:0] : div_sh[31:0]), acc_q[30:0], div_ge};

  assign acc_step = op_q[2] ? div_next : mul_next;

  assign prod_s  = neg_q ? (~acc_step + 64'd1) : acc_step;
  assign mul_res = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
  assign quot    = acc_step[31:0];
  assign rem     = acc_step[63:32];
  assign div_res = op_q[1] ? (neg_q ? (~rem  + 32'd1) : rem)
                           : (neg_q ? (~quot + 32'd1) : quot);
  assign final_res = op_q[2] ? div_res : mul_res;

  // ---------------- next state ----------------
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = f3;
          neg_d   = neg_res;
          count_d = 5'd0;
          if (special) begin
            result_d = spec_res;
            state_d  = S_DONE;
          end else begin
            mcand_d = f3[2] ? mag_b : mag_a;
            acc_d   = {32'd0, (f3[2] ? mag_a : mag_b)};
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d   = acc_step;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          result_d = final_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      mcand_q  <= 32'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = (state_q == S_DONE);
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.stall  = accept || (state_q == S_CALC);

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit: the driver pushes expected results
// (from a plain-arithmetic RV32M model) and a negedge monitor pops and
// compares result, start-to-done latency and stall length on every done.
module tb_rv_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rv_muldiv_if bus ();

  rv_muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          scyc;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  logic        held_chk = 1'b0;
  logic [31:0] last_res = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa = $signed(a);
    longint      sb = $signed(b);
    longint      ub = {32'd0, b};
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ubu = {32'd0, b};
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ubu; return p[31:0]; end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ubu; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ubu; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ubu; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return 32'd0 - $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0;
      held_chk  = 1'b0;
    end else begin
      if (held_chk) begin
        checks++;
        if (bus.result !== last_res) begin
          errors++;
          $display("FAIL result_hold got %h exp %h", bus.result, last_res);
        end
        held_chk = 1'b0;
      end
      if (bus.done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done result %h at cycle %0d", bus.result, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.result !== e.res) begin
            errors++;
            $display("FAIL result f3=%0d A=%h B=%h got %h exp %h", e.f, e.a, e.b, bus.result, e.res);
          end
          checks++;
          if (cyc - e.scyc != e.lat) begin
            errors++;
            $display("FAIL latency f3=%0d A=%h B=%h got %0d exp %0d", e.f, e.a, e.b, cyc - e.scyc, e.lat);
          end
          checks++;
          if (stall_cnt != e.lat) begin
            errors++;
            $display("FAIL stall_len f3=%0d got %0d exp %0d", e.f, stall_cnt, e.lat);
          end
        end
        stall_cnt = 0;
        last_res  = bus.result;
        held_chk  = 1'b1;
      end else if (bus.stall) begin
        stall_cnt++;
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.A      = a;
    bus.B      = b;
    e.res  = ref_model(f, a, b);
    e.lat  = exp_lat(f, a, b);
    e.scyc = cyc;
    e.f = f; e.a = a; e.b = b;
    q.push_back(e);
    @(posedge clk); #1;
    bus.start  = 1'b0;
    // operands wander after accept; the unit must not notice
    bus.funct3 = 3'($urandom);
    bus.A      = $urandom;
    bus.B      = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      if (q.size() == 0) break;
      @(negedge clk); #1;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done, %0d outstanding", q.size());
      q.delete();
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    issue(f, a, b);
    wait_done();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", bus.result, 32'd0);
    chk("reset_done",   {31'd0, bus.done},  32'd0);
    chk("reset_busy",   {31'd0, bus.busy},  32'd0);
    chk("reset_stall",  {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;

    // directed cases
    run(3'd0, 32'd7, 32'hFFFF_FFFD);
    run(3'd1, 32'h8000_0000, 32'h8000_0000);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(3'd4, 32'hFFFF_FFF9, 32'd2);
    run(3'd6, 32'hFFFF_FFF9, 32'd2);
    run(3'd5, 32'd100, 32'd7);
    run(3'd5, 32'd100, 32'd0);
    run(3'd7, 32'd100, 32'd0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'd4, 32'h1234_5678, 32'd0);
    run(3'd6, 32'h1234_5678, 32'd0);

    // start while busy is ignored
    issue(3'd0, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.A = 32'd99; bus.B = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done();

    // reset mid-operation
    issue(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    q.delete();
    chk("abort_busy",   {31'd0, bus.busy},  32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_done",   {31'd0, bus.done},  32'd0);
    chk("abort_stall",  {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    run(3'd0, 32'd3, 32'd5);

    // randomized traffic, some back-to-back, some with idle gaps
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      run(3'($urandom), pick(), pick());
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
